// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmitter and receiver
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        START      = 2'b01,
        DATA_BURST = 2'b10,
        STOP       = 2'b11
    } uart_state_t;
    localparam int   DEF_CLKS_PER_BIT = 521;
    localparam int   DATA_BITS        = 8;
    localparam logic START_LEVEL      = 1'b0;
    localparam logic STOP_LEVEL       = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with wrap-bit pointers for full/empty detection
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_push;
    logic        w_pop;
    assign count  = r_wp - r_rp;
    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = r_wp == r_rp;
    assign dout   = r_mem[r_rp[AW-1:0]];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    // storage write; contents need no reset since empty masks them
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp[AW-1:0]] <= din;
    // pointer advance on accepted push/pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter with valid/ready byte input
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    uart_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitpos;
    logic [7:0]    r_shift;
    logic          r_out;
    logic          r_busy;
    logic          w_full;
    logic          w_empty;
    logic          w_last;
    logic          w_pop;
    logic [7:0]    w_dout;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (tx_clk),
        .rst_n (tx_rst_n),
        .push  (tx_valid && tx_ready),
        .pop   (w_pop),
        .din   (tx_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (tx_fifo_count)
    );
    assign tx_ready = !w_full;
    assign tx_out   = r_out;
    assign tx_busy  = r_busy;
    assign w_last   = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_pop    = !w_empty && (r_state == IDLE || (r_state == STOP && w_last));
    // frame sequencer: output level is registered one step ahead of each state
    always_ff @(posedge tx_clk or negedge tx_rst_n)
        if (!tx_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitpos <= '0;
            r_shift  <= '0;
            r_out    <= STOP_LEVEL;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE:
                    if (w_pop) begin
                        r_shift  <= w_dout;
                        r_cnt    <= '0;
                        r_bitpos <= '0;
                        r_state  <= START;
                        r_out    <= START_LEVEL;
                        r_busy   <= 1'b1;
                    end
                START:
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= DATA_BURST;
                        r_out   <= r_shift[0];
                    end else r_cnt <= r_cnt + 1'b1;
                DATA_BURST:
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_bitpos == 3'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                            r_out   <= STOP_LEVEL;
                        end else begin
                            r_bitpos <= r_bitpos + 3'd1;
                            r_out    <= r_shift[r_bitpos + 3'd1];
                        end
                    end else r_cnt <= r_cnt + 1'b1;
                STOP:
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift  <= w_dout;
                            r_bitpos <= '0;
                            r_state  <= START;
                            r_out    <= START_LEVEL;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else r_cnt <= r_cnt + 1'b1;
            endcase
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench decoding the serial line against the 8N1 frame rules
module tb_uart_tx;
    localparam int CPB  = 8;
    localparam int CPB2 = 16;
    logic       tx_clk = 0;
    logic       tx_rst_n = 0;
    logic [7:0] tx_data = 0;
    logic       tx_valid = 0;
    logic       tx_ready, tx_out, tx_busy;
    logic [2:0] tx_fifo_count;
    logic [7:0] lb_data = 0;
    logic       lb_valid = 0;
    logic       lb_ready, lb_out, lb_busy;
    logic [2:0] lb_count;
    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] exp_q [$];
    int starts [$];
    bit in_frame = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_fifo_count(tx_fifo_count));
    uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(4)) dut_lb (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .tx_data(lb_data), .tx_valid(lb_valid),
        .tx_ready(lb_ready), .tx_out(lb_out), .tx_busy(lb_busy), .tx_fifo_count(lb_count));

    always #5 tx_clk = ~tx_clk;
    always @(posedge tx_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // caller is at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] d);
        int n = 0;
        tx_valid = 1;
        tx_data  = d;
        while (!tx_ready && n < 2000) begin
            @(negedge tx_clk);
            n++;
        end
        if (!tx_ready) chk("send_timeout", 1, 0);
        else begin
            exp_q.push_back(d);
            @(negedge tx_clk);
        end
        tx_valid = 0;
        tx_data  = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || tx_busy) && n < 5000) begin
            @(negedge tx_clk);
            n++;
        end
        chk("drain_timeout", n >= 5000, 0);
    endtask

    // serial-line monitor: decodes each frame one cycle at a time
    initial begin
        logic [9:0] bits;
        bit stable, aborted;
        forever begin
            @(negedge tx_clk);
            if (tx_rst_n && tx_out === 1'b0) begin
                in_frame = 1;
                starts.push_back(cyc);
                stable  = 1;
                aborted = 0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++)
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge tx_clk);
                        if (!tx_rst_n) aborted = 1;
                        else if (c == 0) bits[b] = tx_out;
                        else if (tx_out !== bits[b]) stable = 0;
                    end
                if (!aborted) begin
                    chk("start_bit", bits[0], 0);
                    chk("stop_bit", bits[9], 1);
                    chk("bit_stable", stable, 1);
                    if (exp_q.size() == 0) chk("unexpected_frame", bits[8:1], 32'hFFFF_FFFF);
                    else chk("frame_data", bits[8:1], exp_q.pop_front());
                end
                in_frame = 0;
            end
        end
    end

    // loopback receiver: waits for a start edge, samples mid-bit
    task automatic lb_rx(output logic [7:0] b, output bit ok);
        int n = 0;
        ok = 0;
        b  = 0;
        while (lb_out !== 1'b0 && n < 5000) begin
            @(negedge tx_clk);
            n++;
        end
        if (n >= 5000) return;
        repeat (CPB2 / 2) @(negedge tx_clk);
        if (lb_out !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB2) @(negedge tx_clk);
            b[i] = lb_out;
        end
        repeat (CPB2) @(negedge tx_clk);
        ok = lb_out === 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        bit ok;
        bit hold1;
        // reset idle
        repeat (3) @(negedge tx_clk);
        tx_rst_n = 1;
        repeat (5) @(negedge tx_clk);
        tx_rst_n = 0;
        @(negedge tx_clk);
        tx_rst_n = 1;
        @(negedge tx_clk);
        chk("rst_out", tx_out, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_count", tx_fifo_count, 0);
        chk("rst_busy", tx_busy, 0);
        hold1 = 1;
        repeat (100) begin
            @(negedge tx_clk);
            if (tx_out !== 1'b1) hold1 = 0;
        end
        chk("idle_hold", hold1, 1);
        // single byte with latency and busy length
        tx_valid = 1;
        tx_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(posedge tx_clk);
        #1;
        tx_valid = 0;
        tx_data  = 8'h00;
        chk("no_bypass_out", tx_out, 1);
        chk("count_after_push", tx_fifo_count, 1);
        @(posedge tx_clk);
        #1;
        chk("latency_out", tx_out, 0);
        chk("latency_busy", tx_busy, 1);
        chk("count_after_pop", tx_fifo_count, 0);
        repeat (79) @(posedge tx_clk);
        #1;
        chk("busy_at_79", tx_busy, 1);
        @(posedge tx_clk);
        #1;
        chk("busy_at_80", tx_busy, 0);
        @(negedge tx_clk);
        drain();
        // back-to-back
        starts.delete();
        send(8'h00);
        send(8'hFF);
        send(8'h55);
        send(8'h0F);
        send(8'h33);
        chk("b2b_accepted", exp_q.size(), 5);
        drain();
        chk("b2b_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) chk("b2b_spacing", starts[i] - starts[i-1], 80);
        // full handling
        send(8'h00);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        chk("full_count", tx_fifo_count, 4);
        chk("full_ready", tx_ready, 0);
        tx_valid = 1;
        tx_data  = 8'h99;
        repeat (5) @(negedge tx_clk);
        chk("full_held_count", tx_fifo_count, 4);
        send(8'h99);
        drain();
        // reset mid-frame during bit 3 of C3
        send(8'hC3);
        repeat (36) @(negedge tx_clk);
        chk("bit3_level", tx_out, 0);
        #2;
        tx_rst_n = 0;
        #1;
        chk("async_rst_out", tx_out, 1);
        exp_q.delete();
        repeat (3) @(negedge tx_clk);
        tx_rst_n = 1;
        @(negedge tx_clk);
        chk("post_rst_count", tx_fifo_count, 0);
        chk("post_rst_busy", tx_busy, 0);
        send(8'h5A);
        drain();
        // randomized traffic
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 100)) @(negedge tx_clk);
        end
        drain();
        chk("queue_empty", exp_q.size(), 0);
        // loopback at 16 clocks per bit
        lb_valid = 1;
        lb_data  = 8'h3C;
        @(negedge tx_clk);
        lb_data  = 8'hE7;
        @(negedge tx_clk);
        lb_valid = 0;
        lb_data  = 8'h00;
        lb_rx(rb, ok);
        chk("lb_frame0_ok", ok, 1);
        chk("lb_byte0", rb, 8'h3C);
        lb_rx(rb, ok);
        chk("lb_frame1_ok", ok, 1);
        chk("lb_byte1", rb, 8'hE7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
